display_mux_ctrl: RTL

Controller that owns the 4-digit seven-segment display datapath. It decides which source (timekeeper, stopwatch or alarm setting) drives the display's ones/tens/hundreds/thousands BCD inputs. It runs the user mode FSM (view cycling, alarm-digit editing, inactivity timeout) and generates per-digit blanking for blink and leading-zero suppression. It sits between the debounced buttons / time sources and the display scanner.

---
 rtl/display_mux_ctrl_pkg.sv | 29 ++
 rtl/display_mux_ctrl_blink.sv | 32 +++
 rtl/display_mux_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/display_mux_ctrl_pkg.sv
// Shared definitions for the display mux controller: mode encodings,
// digit indices and BCD helpers.
package display_mux_ctrl_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned WORD_W     = NUM_DIGITS * BCD_W;

  typedef enum logic [1:0] {
    MODE_TIME  = 2'd0,
    MODE_SW    = 2'd1,
    MODE_ALARM = 2'd2,
    MODE_EDIT  = 2'd3
  } mode_e;

  typedef logic [1:0]       digit_idx_t;
  typedef logic [BCD_W-1:0] bcd_t;

  localparam digit_idx_t DIG_ONES      = 2'd0;
  localparam digit_idx_t DIG_TENS      = 2'd1;
  localparam digit_idx_t DIG_HUNDREDS  = 2'd2;
  localparam digit_idx_t DIG_THOUSANDS = 2'd3;

  // Extract one BCD nibble from a packed four-digit word; thousands sits in the top nibble.
  function automatic bcd_t bcd_nibble(input logic [WORD_W-1:0] word, input digit_idx_t idx);
    return word[idx*BCD_W +: BCD_W];
  endfunction

endpackage

// File: rtl/display_mux_ctrl_blink.sv
// Free-running blink phase generator shared by the watch display blocks.
// Phase starts ON after reset and toggles every BLINK_HALF clock cycles.
module blink_gen #(
  parameter int unsigned BLINK_HALF = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic phase
);

  localparam int unsigned     CntW    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BLINK_HALF - 1);

  logic [CntW-1:0] cnt_q;
  logic            phase_q;

  // Count out one half-period, then flip the phase and start over.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (cnt_q == CntLast) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/display_mux_ctrl.sv
// Display mux controller: owns the user mode FSM (view cycling, alarm digit
// editing, inactivity timeout), selects the BCD source for the four display
// digits and produces per-digit blanking for blink and leading-zero suppression.
// All outputs are registered and reflect the inputs of the previous cycle.
module display_mux_ctrl
  import display_mux_ctrl_pkg::*;
#(
  parameter int unsigned BLINK_HALF  = 25_000_000,
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_sel,
  input  logic        sec_tick,
  input  logic [15:0] time_bcd,
  input  logic [15:0] sw_bcd,
  input  logic [15:0] alarm_bcd,
  input  logic        sw_running,
  input  logic        alarm_pending,
  output logic [3:0]  ones,
  output logic [3:0]  tens,
  output logic [3:0]  hundreds,
  output logic [3:0]  thousands,
  output logic [3:0]  blank,
  output logic [1:0]  mode,
  output logic [1:0]  edit_digit,
  output logic        adj_pulse,
  output logic        alarm_ack
);

  localparam int unsigned    ToW   = (TIMEOUT_SEC > 0) ? $clog2(TIMEOUT_SEC + 1) : 1;
  localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT_SEC);

  mode_e              mode_q, mode_d;
  digit_idx_t         edit_q, edit_d;
  logic [ToW-1:0]     to_q, to_d;
  logic               adj_q, adj_d;
  logic               ack_q, ack_d;
  bcd_t               ones_q, tens_q, hund_q, thou_q;
  logic [3:0]         blank_q, blank_d;
  logic [WORD_W-1:0]  src;
  logic               lz_en;
  logic [3:0]         edit_mask;
  logic               phase;
  logic               any_btn;
  logic               timed_out;
  logic               tick_counts;

  blink_gen #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink (
    .clk  (clk),
    .rst  (rst),
    .phase(phase)
  );

  assign any_btn     = btn_mode | btn_sel;
  assign timed_out   = (mode_q != MODE_TIME) && (to_q >= ToMax);
  // A running stopwatch is being watched, so its seconds do not count as idle time.
  assign tick_counts = !((mode_q == MODE_SW) && sw_running);

  // Mode FSM, edit digit and timeout counter next-state; btn_sel beats btn_mode.
  always_comb begin
    mode_d = mode_q;
    edit_d = edit_q;
    to_d   = to_q;
    adj_d  = 1'b0;
    ack_d  = 1'b0;
    if (alarm_pending) begin
      // Everything freezes; a press only acknowledges the alarm.
      ack_d = any_btn;
    end else if (timed_out) begin
      mode_d = MODE_TIME;
      to_d   = '0;
    end else begin
      unique case (mode_q)
        MODE_TIME: begin
          if (!btn_sel && btn_mode) mode_d = MODE_SW;
        end
        MODE_SW: begin
          if (!btn_sel && btn_mode) mode_d = MODE_ALARM;
        end
        MODE_ALARM: begin
          if (btn_sel) begin
            mode_d = MODE_EDIT;
            edit_d = DIG_THOUSANDS;
          end else if (btn_mode) begin
            mode_d = MODE_TIME;
          end
        end
        MODE_EDIT: begin
          if (btn_sel) begin
            if (edit_q == DIG_ONES) mode_d = MODE_ALARM;
            else                    edit_d = edit_q - 2'd1;
          end else if (btn_mode) begin
            adj_d = 1'b1;
          end
        end
        default: ;
      endcase
      if (any_btn || (mode_d != mode_q) || (mode_q == MODE_TIME)) begin
        to_d = '0;
      end else if (sec_tick && tick_counts) begin
        to_d = to_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_TIME;
      edit_q <= DIG_THOUSANDS;
      to_q   <= '0;
    end else begin
      mode_q <= mode_d;
      edit_q <= edit_d;
      to_q   <= to_d;
    end
  end

  // Source select and blanking, evaluated for the state being entered.
  always_comb begin
    src       = time_bcd;
    lz_en     = 1'b1;
    blank_d   = '0;
    edit_mask = 4'b0001 << edit_d;
    if (!alarm_pending) begin
      unique case (mode_d)
        MODE_TIME:  begin src = time_bcd;  lz_en = 1'b1; end
        MODE_SW:    begin src = sw_bcd;    lz_en = 1'b0; end
        MODE_ALARM: begin src = alarm_bcd; lz_en = 1'b1; end
        // The thousands digit stays visible while it is the one being edited.
        MODE_EDIT:  begin src = alarm_bcd; lz_en = (edit_d != DIG_THOUSANDS); end
        default: ;
      endcase
    end
    if (lz_en && (bcd_nibble(src, DIG_THOUSANDS) == '0)) begin
      blank_d[DIG_THOUSANDS] = 1'b1;
    end
    if (!phase) begin
      if (alarm_pending)               blank_d = '1;
      else if (mode_d == MODE_EDIT)    blank_d = blank_d | edit_mask;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q  <= '0;
      tens_q  <= '0;
      hund_q  <= '0;
      thou_q  <= '0;
      blank_q <= '0;
      adj_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ones_q  <= bcd_nibble(src, DIG_ONES);
      tens_q  <= bcd_nibble(src, DIG_TENS);
      hund_q  <= bcd_nibble(src, DIG_HUNDREDS);
      thou_q  <= bcd_nibble(src, DIG_THOUSANDS);
      blank_q <= blank_d;
      adj_q   <= adj_d;
      ack_q   <= ack_d;
    end
  end

  assign ones       = ones_q;
  assign tens       = tens_q;
  assign hundreds   = hund_q;
  assign thousands  = thou_q;
  assign blank      = blank_q;
  assign mode       = mode_q;
  assign edit_digit = edit_q;
  assign adj_pulse  = adj_q;
  assign alarm_ack  = ack_q;

endmodule
